// File: rtl/fl_ckpt_ctrl.sv
// ---------------------------------------------------------------------------
// fl_ckpt_ctrl -- free-list checkpoint controller for branch speculation.
//
// Each dispatched branch takes a checkpoint slot holding the free-list tail
// in effect at dispatch. Slots form a circular queue ordered oldest (head)
// to youngest (tail - 1). Correct resolves may arrive out of order. A slot is
// released only when head walks past it. A mispredict truncates the queue at
// the offending branch and, one cycle later, pulses the stored free-list tail
// out so the free list can roll back.
//
// Ports
//   clock              : system clock, rising edge
//   reset              : asynchronous, active-low reset
//   branch_dispatch_en : a branch dispatches and wants a checkpoint
//   dispatch_FL_tail   : free-list tail to save for that branch
//   resolve_en         : a branch resolves this cycle
//   resolve_tag        : checkpoint tag of the resolving branch
//   resolve_mispredict : the resolving branch mispredicted
//   flush_en           : discard every checkpoint (no rollback pulse)
//   ckpt_avail         : a free slot exists
//   ckpt_tag           : tag the next dispatched branch will receive
//   rollback_en        : one-cycle registered rollback pulse
//   FL_rollback_idx    : restored free-list tail, held between pulses
//   ckpt_count         : number of allocated slots
// ---------------------------------------------------------------------------
module fl_ckpt_ctrl #(
    parameter int NUM_CKPT = 4,
    parameter int FL_IDX_W = 5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        branch_dispatch_en,
    input  logic [FL_IDX_W-1:0]         dispatch_FL_tail,
    input  logic                        resolve_en,
    input  logic [$clog2(NUM_CKPT)-1:0] resolve_tag,
    input  logic                        resolve_mispredict,
    input  logic                        flush_en,
    output logic                        ckpt_avail,
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_tag,
    output logic                        rollback_en,
    output logic [FL_IDX_W-1:0]         FL_rollback_idx,
    output logic [$clog2(NUM_CKPT):0]   ckpt_count
);

    localparam int TAG_W = $clog2(NUM_CKPT);
    localparam int CNT_W = TAG_W + 1;

    // Registered state
    logic [TAG_W-1:0]    head_reg, head_next;
    logic [TAG_W-1:0]    tail_reg, tail_next;
    logic [NUM_CKPT-1:0] valid_reg, valid_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                rollback_en_reg;
    logic [FL_IDX_W-1:0] rollback_idx_reg;
    logic [FL_IDX_W-1:0] ckpt_idx_reg [NUM_CKPT];

    // Event qualification. Flush dominates everything; an accepted
    // mispredict kills a same-cycle dispatch (wrong-path branch).
    logic tag_live;
    logic mispredict_acc;
    logic correct_acc;
    logic alloc_acc;

    assign ckpt_avail     = (count_reg != CNT_W'(NUM_CKPT));
    assign ckpt_tag       = tail_reg;
    assign ckpt_count     = count_reg;
    assign rollback_en    = rollback_en_reg;
    assign FL_rollback_idx = rollback_idx_reg;

    assign tag_live       = valid_reg[resolve_tag];
    assign mispredict_acc = resolve_en & resolve_mispredict & tag_live & ~flush_en;
    assign correct_acc    = resolve_en & ~resolve_mispredict & tag_live & ~flush_en;
    assign alloc_acc      = branch_dispatch_en & ckpt_avail & ~mispredict_acc & ~flush_en;

    // Age of the mispredicting slot relative to head. Slots at least this old
    // (distance from head below it) survive the squash; everything from the
    // mispredicting slot onward is discarded.
    logic [TAG_W-1:0]    tag_dist;
    logic [NUM_CKPT-1:0] keep_mask;
    logic [NUM_CKPT-1:0] clr_mask;
    logic [NUM_CKPT-1:0] alloc_mask;

    assign tag_dist = resolve_tag - head_reg;

    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_slot
            logic [TAG_W-1:0] slot_dist;
            assign slot_dist      = TAG_W'(gi) - head_reg;
            assign keep_mask[gi]  = (slot_dist < tag_dist);
            assign clr_mask[gi]   = correct_acc && (resolve_tag == TAG_W'(gi));
            assign alloc_mask[gi] = alloc_acc && (tail_reg == TAG_W'(gi));
        end
    endgenerate

    // Next-state logic
    logic [NUM_CKPT-1:0] resolved_valid;
    logic [CNT_W-1:0]    adv;
    logic                scanning;
    logic [TAG_W-1:0]    scan_ptr;

    assign resolved_valid = valid_reg & ~clr_mask;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        valid_next = valid_reg;
        count_next = count_reg;
        adv        = '0;
        scanning   = 1'b1;
        scan_ptr   = head_reg;

        if (flush_en) begin
            head_next  = '0;
            tail_next  = '0;
            valid_next = '0;
            count_next = '0;
        end else if (mispredict_acc) begin
            // Head is live whenever the queue is non-empty, so it cannot
            // move here; the new occupancy is simply the distance to the tag.
            tail_next  = resolve_tag;
            valid_next = valid_reg & keep_mask;
            count_next = {1'b0, tag_dist};
        end else begin
            // Walk from head over cleared slots, bounded by the occupancy
            // seen before this cycle's allocation so a slot being written
            // right now can never be skipped.
            for (int i = 0; i < NUM_CKPT; i++) begin
                scan_ptr = head_reg + TAG_W'(i);
                if (scanning && (CNT_W'(i) < count_reg) && !resolved_valid[scan_ptr]) begin
                    adv = adv + 1'b1;
                end else begin
                    scanning = 1'b0;
                end
            end
            head_next  = head_reg + adv[TAG_W-1:0];
            valid_next = resolved_valid | alloc_mask;
            count_next = count_reg - adv + {{(CNT_W-1){1'b0}}, alloc_acc};
            if (alloc_acc) begin
                tail_next = tail_reg + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            valid_reg        <= '0;
            count_reg        <= '0;
            rollback_en_reg  <= 1'b0;
            rollback_idx_reg <= '0;
        end else begin
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            valid_reg       <= valid_next;
            count_reg       <= count_next;
            rollback_en_reg <= mispredict_acc;
            if (mispredict_acc) begin
                rollback_idx_reg <= ckpt_idx_reg[resolve_tag];
            end
        end
    end

    // Checkpoint storage; cleared on reset, so it lives in flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_idx_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (alloc_mask[i]) begin
                    ckpt_idx_reg[i] <= dispatch_FL_tail;
                end
            end
        end
    end

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for fl_ckpt_ctrl. A queue-of-branches model (oldest first) tracks
// which tags are live, which are resolved, and the expected outputs.
// ---------------------------------------------------------------------------
module tb_fl_ckpt_ctrl;

    localparam int NUM = 4;

    logic       clock;
    logic       reset;
    logic       branch_dispatch_en;
    logic [4:0] dispatch_FL_tail;
    logic       resolve_en;
    logic [1:0] resolve_tag;
    logic       resolve_mispredict;
    logic       flush_en;
    logic       ckpt_avail;
    logic [1:0] ckpt_tag;
    logic       rollback_en;
    logic [4:0] FL_rollback_idx;
    logic [2:0] ckpt_count;

    fl_ckpt_ctrl #(.NUM_CKPT(NUM), .FL_IDX_W(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .branch_dispatch_en (branch_dispatch_en),
        .dispatch_FL_tail   (dispatch_FL_tail),
        .resolve_en         (resolve_en),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .flush_en           (flush_en),
        .ckpt_avail         (ckpt_avail),
        .ckpt_tag           (ckpt_tag),
        .rollback_en        (rollback_en),
        .FL_rollback_idx    (FL_rollback_idx),
        .ckpt_count         (ckpt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: in-flight branches, oldest first.
    typedef struct {
        int tag;
        int fl;
        bit done;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    bit   m_rb_en;
    int   m_rb_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    function automatic int find_live(input int t);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == t && !q[i].done) return i;
        end
        return -1;
    endfunction

    function automatic int m_head();
        return (q.size() > 0) ? q[0].tag : m_tail;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail   = 0;
        m_rb_en  = 0;
        m_rb_idx = 0;
    endtask

    task automatic model_step(input bit d, input int fl, input bit r, input int t,
                              input bit m, input bit f);
        int   k;
        bit   can;
        ent_t e;
        k = r ? find_live(t) : -1;
        m_rb_en = 0;
        if (f) begin
            q.delete();
            m_tail = 0;
        end else if (r && m && k >= 0) begin
            m_rb_en  = 1;
            m_rb_idx = q[k].fl;
            while (q.size() > k) void'(q.pop_back());
            m_tail = t;
        end else begin
            can = d && (q.size() < NUM);
            if (r && !m && k >= 0) begin
                e = q[k];
                e.done = 1;
                q[k] = e;
            end
            while (q.size() > 0 && q[0].done) void'(q.pop_front());
            if (can) begin
                e.tag  = m_tail;
                e.fl   = fl;
                e.done = 0;
                q.push_back(e);
                m_tail = (m_tail + 1) % NUM;
            end
        end
    endtask

    task automatic check_all(input string step);
        check({step, ".count"}, 32'(ckpt_count), 32'(q.size()));
        check({step, ".avail"}, 32'(ckpt_avail), 32'(q.size() != NUM));
        check({step, ".tag"},   32'(ckpt_tag),   32'(m_tail));
        check({step, ".rb_en"}, 32'(rollback_en), 32'(m_rb_en));
        check({step, ".rb_idx"}, 32'(FL_rollback_idx), 32'(m_rb_idx));
        check({step, ".head"},  32'(dut.head_reg), 32'(m_head()));
    endtask

    task automatic cycle(input bit d, input int fl, input bit r, input int t,
                         input bit m, input bit f);
        branch_dispatch_en = d;
        dispatch_FL_tail   = fl[4:0];
        resolve_en         = r;
        resolve_tag        = t[1:0];
        resolve_mispredict = m;
        flush_en           = f;
        model_step(d, fl, r, t, m, f);
        @(posedge clock);
        #1;
        cyc++;
        check_all($sformatf("cyc%0d", cyc));
        $display("cyc %0d: disp=%0b fl=%0d res=%0b tag=%0d mis=%0b flush=%0b -> count=%0d ckpt_tag=%0d rb=%0b/%0d",
                 cyc, d, fl, r, t, m, f, ckpt_count, ckpt_tag, rollback_en, FL_rollback_idx);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    int tails[4];

    initial begin
        tails = '{3, 7, 9, 12};
        branch_dispatch_en = 0;
        dispatch_FL_tail   = 0;
        resolve_en         = 0;
        resolve_tag        = 0;
        resolve_mispredict = 0;
        flush_en           = 0;
        model_reset();

        // Reset, checked before any clock edge
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_all("reset");
        check("reset.avail_const", 32'(ckpt_avail), 32'd1);
        check("reset.tag_const", 32'(ckpt_tag), 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;

        // Allocation to full
        for (int i = 0; i < 4; i++) begin
            check("alloc.tag_before", 32'(ckpt_tag), 32'(i));
            cycle(1, tails[i], 0, 0, 0, 0);
        end
        check("full.count", 32'(ckpt_count), 32'd4);
        check("full.avail", 32'(ckpt_avail), 32'd0);
        cycle(1, 20, 0, 0, 0, 0);
        check("fifth_ignored.count", 32'(ckpt_count), 32'd4);

        // Mispredict tag 1 from full
        cycle(0, 0, 1, 1, 1, 0);
        check("mis1.rb_en", 32'(rollback_en), 32'd1);
        check("mis1.rb_idx", 32'(FL_rollback_idx), 32'd7);
        check("mis1.count", 32'(ckpt_count), 32'd1);
        check("mis1.tail", 32'(ckpt_tag), 32'd1);
        idle();
        check("mis1.pulse_end", 32'(rollback_en), 32'd0);
        check("mis1.idx_hold", 32'(FL_rollback_idx), 32'd7);
        cycle(0, 0, 1, 2, 0, 0);
        check("squashed_resolve.count", 32'(ckpt_count), 32'd1);
        cycle(0, 0, 1, 2, 1, 0);
        check("squashed_mis.rb_en", 32'(rollback_en), 32'd0);

        // Out-of-order resolve
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 10 + i, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0);
        check("ooo.count_stays", 32'(ckpt_count), 32'd3);
        cycle(0, 0, 1, 0, 0, 0);
        check("ooo.count", 32'(ckpt_count), 32'd1);
        check("ooo.head", 32'(dut.head_reg), 32'd2);

        // Wrap-around
        cycle(0, 0, 1, 2, 0, 0);
        check("wrap.head", 32'(dut.head_reg), 32'd3);
        check("wrap.tail", 32'(ckpt_tag), 32'd3);
        check("wrap.empty", 32'(ckpt_count), 32'd0);
        cycle(1, 21, 0, 0, 0, 0);
        check("wrap.tag_after_first", 32'(ckpt_tag), 32'd0);
        cycle(1, 22, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1, 0);
        check("wrap.mis_tail", 32'(ckpt_tag), 32'd0);
        check("wrap.mis_count", 32'(ckpt_count), 32'd1);
        check("wrap.rb_idx", 32'(FL_rollback_idx), 32'd22);

        // Simultaneous events
        idle();
        cycle(1, 23, 0, 0, 0, 0);
        cycle(1, 25, 1, 0, 1, 0);
        check("sim.no_alloc_count", 32'(ckpt_count), 32'd1);
        check("sim.rb_en", 32'(rollback_en), 32'd1);
        check("sim.rb_idx", 32'(FL_rollback_idx), 32'd23);
        cycle(0, 0, 1, 3, 1, 1);
        check("flush_mis.count", 32'(ckpt_count), 32'd0);
        check("flush_mis.rb_en", 32'(rollback_en), 32'd0);
        idle();
        check("flush_mis.rb_en_later", 32'(rollback_en), 32'd0);

        // Asynchronous reset mid-cycle with live checkpoints and a pending pulse
        for (int i = 0; i < 4; i++) cycle(1, 26 + i, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 1, 0);
        check("pre_rst.count", 32'(ckpt_count), 32'd3);
        check("pre_rst.rb_en", 32'(rollback_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.count_const", 32'(ckpt_count), 32'd0);
        check("async_rst.rb_const", 32'(rollback_en), 32'd0);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_all("rst_release");

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            bit d, r, m, f;
            int fl, t;
            d  = ($urandom_range(0, 9) < 6);
            fl = $urandom_range(0, 31);
            r  = ($urandom_range(0, 9) < 5);
            t  = $urandom_range(0, NUM - 1);
            m  = ($urandom_range(0, 7) == 0);
            f  = ($urandom_range(0, 39) == 0);
            cycle(d, fl, r, t, m, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
